// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg
//   Shared definitions for the push-button debouncer: FSM state encodings and
//   the default timing constants for a 48 MHz clock.
package sw_debounce_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_P_WAIT = 2'd1;
  localparam logic [1:0] ST_HELD   = 2'd2;
  localparam logic [1:0] ST_R_WAIT = 2'd3;

  // 10 ms debounce window and 1 s long-press time at 48 MHz
  localparam int DB_CYCLES_48M   = 480000;
  localparam int LONG_CYCLES_48M = 48000000;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for a single asynchronous input pin. Shared by
//   other pin inputs, so the reset value is a parameter: it should be the
//   pin's idle level so that reset exit never looks like an edge.
// Ports
//   i_clk    in  system clock
//   i_rst_n  in  synchronous active-low reset
//   d        in  asynchronous input
//   q        out synchronised output
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce
//   Debounces a raw mechanical switch pin. The pin is synchronised, normalised
//   to 1 = pressed, and a level change is accepted only after the new value
//   has been stable for DB_CYCLES counted cycles. Emits one-cycle press and
//   release strobes alongside the filtered level.
//   Optional long-press strobe enabled by defining SW_LONG_PRESS_EN.
// Ports
//   i_clk      in  system clock
//   i_rst_n    in  synchronous active-low reset
//   i_sw       in  raw switch pin
//   o_level    out debounced level, 1 = pressed
//   o_press    out 1-cycle strobe on accepted press
//   o_release  out 1-cycle strobe on accepted release
//   o_long     out 1-cycle strobe after LONG_CYCLES held (0 when disabled)
//
// state     | meaning
// ST_IDLE   | stable released
// ST_P_WAIT | pressed seen, counting stable pressed cycles
// ST_HELD   | stable pressed
// ST_R_WAIT | released seen, counting stable released cycles
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_48M,
  parameter int CNT_W       = 20,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int LONG_CYCLES = LONG_CYCLES_48M,
  parameter int LONG_W      = 26
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sw_q;
  logic             s_press;
  logic [1:0]       state;
  logic [CNT_W-1:0] db_cnt;

  // Reset loads the released pin level so reset exit is not seen as a press.
  sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .d       (i_sw),
    .q       (sw_q)
  );

  assign s_press = sw_q ^ ACTIVE_LOW;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      db_cnt    <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_press) begin
            state  <= ST_P_WAIT;
            db_cnt <= '0;
          end
        end
        ST_P_WAIT: begin
          if (!s_press) begin
            state  <= ST_IDLE;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state   <= ST_HELD;
            db_cnt  <= '0;
            o_level <= 1'b1;
            o_press <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (!s_press) begin
            state  <= ST_R_WAIT;
            db_cnt <= '0;
          end
        end
        ST_R_WAIT: begin
          if (s_press) begin
            state  <= ST_HELD;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state     <= ST_IDLE;
            db_cnt    <= '0;
            o_level   <= 1'b0;
            o_release <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

`ifdef SW_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  // One past the last count marks "already fired" until the next press.
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

  logic [LONG_W-1:0] long_cnt;

  // R_WAIT keeps counting so release bounces do not restart the hold time.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      long_cnt <= '0;
      o_long   <= 1'b0;
    end else begin
      o_long <= 1'b0;
      if (state == ST_HELD || state == ST_R_WAIT) begin
        if (long_cnt == LONG_LAST) begin
          o_long   <= 1'b1;
          long_cnt <= LONG_SAT;
        end else if (long_cnt != LONG_SAT) begin
          long_cnt <= long_cnt + 1'b1;
        end
      end else begin
        long_cnt <= '0;
      end
    end
  end
`else
  logic unused_long_cfg;
  assign unused_long_cfg = ^{LONG_CYCLES, LONG_W};
  assign o_long = 1'b0;
`endif

endmodule
